// File: rtl/command_definition_pkg.sv
// Shared command encoding and arbiter state types
// for the bank command path.
package command_definition_pkg;

  localparam int BA_BITS  = 3;
  localparam int ROW_BITS = 16;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_ACTIVE    = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_PRECHARGE = 3'd4,
    CMD_REFRESH   = 3'd5
  } cmd_t;

  typedef struct packed {
    cmd_t                cmd;
    logic [BA_BITS-1:0]  bank_address;
    logic [ROW_BITS-1:0] addr;
  } bank_command_t;

  typedef enum logic [1:0] {
    ARB_RUN,
    ARB_REF_PRE,
    ARB_REF_CMD,
    ARB_REF_DONE
  } arb_fsm_state_t;

  function automatic logic [BA_BITS-1:0] lowest_set(
    input logic [2**BA_BITS-1:0] v
  );
    lowest_set = '0;
    for (int i = 2**BA_BITS-1; i >= 0; i--)
      if (v[i]) lowest_set = BA_BITS'(i);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible
// channel strictly after the pointer, wrapping.
module rr_priority_picker #(
  parameter int NUM_BANKS = 8,
  localparam int IW = $clog2(NUM_BANKS)
) (
  input  logic [NUM_BANKS-1:0] i_eligible,
  input  logic [IW-1:0]        i_rr_ptr,
  output logic [NUM_BANKS-1:0] o_grant,
  output logic [IW-1:0]        o_index,
  output logic                 o_found
);

  logic [IW-1:0] w_idx;

  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    o_grant = '0;
    w_idx   = '0;
    // k == NUM_BANKS wraps back to the pointer itself
    for (int k = 1; k <= NUM_BANKS; k++) begin
      w_idx = i_rr_ptr + IW'(k);
      if (!o_found && i_eligible[w_idx]) begin
        o_found = 1'b1;
        o_index = w_idx;
      end
    end
    if (o_found) o_grant[o_index] = 1'b1;
  end

endmodule

// File: rtl/bank_command_arbiter.sv
// Merges per-bank command channels into the issue FIFO,
// enforcing tRRD/tFAW and sequencing refresh.
module bank_command_arbiter
  import command_definition_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int TRRD      = 4,
  parameter int TFAW      = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_BANKS-1:0]          i_req_valid,
  input  bank_command_t [NUM_BANKS-1:0] i_req_cmd,
  output logic [NUM_BANKS-1:0]          o_req_grant,
  input  logic                          i_refresh_req,
  output logic                          o_refresh_ack,
  output bank_command_t                 o_issue_command,
  output logic                          o_issue_wen,
  input  logic                          i_issue_queue_full
);

  localparam int IW = $clog2(NUM_BANKS);
  localparam int RW = $clog2(TRRD) + 1;
  localparam int FW = $clog2(TFAW);

  arb_fsm_state_t        r_state;
  arb_fsm_state_t        w_next;
  logic [IW-1:0]         r_rr_ptr;
  logic [NUM_BANKS-1:0]  r_open_bank;
  logic [RW-1:0]         r_trrd;
  logic [3:0]            w_faw_zero;
  logic [3:0]            w_faw_sel;
  logic                  w_faw_found;
  logic                  w_act_ok;
  logic [NUM_BANKS-1:0]  w_elig;
  logic [NUM_BANKS-1:0]  w_pick_grant;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_pick_found;
  logic                  w_grant_en;
  logic                  w_emit;
  logic                  w_act_grant;
  bank_command_t         w_emit_cmd;
  logic                  r_wen;
  bank_command_t         r_cmd;
  logic                  r_ack;

  assign w_act_ok = (r_trrd == '0) && (|w_faw_zero);

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      w_elig[i] = i_req_valid[i] &&
        ((i_req_cmd[i].cmd != CMD_ACTIVE) || w_act_ok);
  end

  rr_priority_picker #(
    .NUM_BANKS(NUM_BANKS)
  ) u_picker (
    .i_eligible(w_elig),
    .i_rr_ptr  (r_rr_ptr),
    .o_grant   (w_pick_grant),
    .o_index   (w_pick_idx),
    .o_found   (w_pick_found)
  );

  always_comb begin
    w_faw_sel   = '0;
    w_faw_found = 1'b0;
    for (int g = 0; g < 4; g++) begin
      if (w_faw_zero[g] && !w_faw_found) begin
        w_faw_sel[g] = 1'b1;
        w_faw_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_grant_en  = 1'b0;
    w_emit      = 1'b0;
    w_act_grant = 1'b0;
    w_emit_cmd  = '0;
    unique case (r_state)
      ARB_RUN: begin
        if (i_issue_queue_full) begin
          w_next = r_state;
        end else if (i_refresh_req) begin
          w_next = ARB_REF_PRE;
        end else if (w_pick_found) begin
          w_grant_en  = 1'b1;
          w_emit      = 1'b1;
          w_emit_cmd  = i_req_cmd[w_pick_idx];
          w_act_grant = (w_emit_cmd.cmd == CMD_ACTIVE);
        end
      end
      ARB_REF_PRE: begin
        if (!i_issue_queue_full) begin
          if (r_open_bank == '0) begin
            w_next = ARB_REF_CMD;
          end else begin
            w_emit = 1'b1;
            w_emit_cmd.cmd = CMD_PRECHARGE;
            w_emit_cmd.bank_address = lowest_set(r_open_bank);
          end
        end
      end
      ARB_REF_CMD: begin
        if (!i_issue_queue_full) begin
          w_emit = 1'b1;
          w_emit_cmd.cmd = CMD_REFRESH;
          w_next = ARB_REF_DONE;
        end
      end
      ARB_REF_DONE: begin
        w_next = ARB_RUN;
      end
    endcase
  end

  assign o_req_grant = w_grant_en ? w_pick_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_RUN;
      r_rr_ptr    <= IW'(NUM_BANKS - 1);
      r_open_bank <= '0;
      r_wen       <= 1'b0;
      r_cmd       <= '0;
      r_ack       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wen   <= w_emit;
      r_ack   <= (w_next == ARB_REF_DONE);
      if (w_grant_en) r_rr_ptr <= w_pick_idx;
      if (w_emit) begin
        r_cmd <= w_emit_cmd;
        if (w_emit_cmd.cmd == CMD_ACTIVE)
          r_open_bank[w_emit_cmd.bank_address] <= 1'b1;
        else if (w_emit_cmd.cmd == CMD_PRECHARGE)
          r_open_bank[w_emit_cmd.bank_address] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_trrd <= '0;
    else if (w_act_grant)
      r_trrd <= RW'(TRRD - 1);
    else if (r_trrd != '0)
      r_trrd <= r_trrd - RW'(1);
  end

  // Four slots: each ACT occupies the lowest free one for TFAW cycles
  for (genvar g = 0; g < 4; g++) begin : g_faw
    logic [FW-1:0] r_faw;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_faw <= '0;
      else if (w_act_grant && w_faw_sel[g])
        r_faw <= FW'(TFAW - 1);
      else if (r_faw != '0)
        r_faw <= r_faw - FW'(1);
    end
    assign w_faw_zero[g] = (r_faw == '0);
  end

  assign o_issue_wen     = r_wen;
  assign o_issue_command = r_cmd;
  assign o_refresh_ack   = r_ack;

endmodule

// File: tb/tb_bank_command_arbiter.sv
// Directed bench for bank_command_arbiter: round-robin,
// tRRD/tFAW spacing, refresh sequencing, full FIFO, reset.
module tb_bank_command_arbiter;
  import command_definition_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [7:0]            req_valid;
  bank_command_t [7:0]   req_cmd;
  logic [7:0]            grant;
  logic                  refresh_req;
  logic                  ack;
  bank_command_t         issue_cmd;
  logic                  wen;
  logic                  full;

  int checks = 0;
  int errors = 0;

  int            q_cnt [8];
  bank_command_t q_cmd [8];

  bank_command_arbiter #(
    .NUM_BANKS(8),
    .TRRD(4),
    .TFAW(20)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_req_valid       (req_valid),
    .i_req_cmd         (req_cmd),
    .o_req_grant       (grant),
    .i_refresh_req     (refresh_req),
    .o_refresh_ack     (ack),
    .o_issue_command   (issue_cmd),
    .o_issue_wen       (wen),
    .i_issue_queue_full(full)
  );

  always #5 clk = ~clk;

  function automatic bank_command_t mk(input cmd_t c,
                                       input int ba);
    bank_command_t b;
    b = '0;
    b.cmd = c;
    b.bank_address = 3'(ba);
    b.addr = 16'(ba * 16'h111);
    return b;
  endfunction

  task automatic clear_q();
    for (int i = 0; i < 8; i++) begin
      q_cnt[i] = 0;
      q_cmd[i] = '0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 8; i++) begin
      req_valid[i] = (q_cnt[i] > 0);
      req_cmd[i]   = q_cmd[i];
    end
  endtask

  // One cycle: drive at negedge, sample grant, pop after edge
  task automatic step(output logic [7:0] g);
    @(negedge clk);
    drive();
    #1 g = grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      if (g[i] && q_cnt[i] > 0) q_cnt[i]--;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    refresh_req = 1'b0;
    full = 1'b0;
    clear_q();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] g;
    @(negedge clk);
    rst_n = 1'b0;
    refresh_req = 1'b0;
    full = 1'b0;
    clear_q();
    drive();
    #1;
    checks++;
    if (wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_wen got %0b want 0", wen);
    end
    checks++;
    if (issue_cmd !== bank_command_t'('0)) begin
      errors++;
      $display("FAIL reset_cmd got %h want 0", issue_cmd);
    end
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack got %0b want 0", ack);
    end
    checks++;
    if (grant !== 8'h00) begin
      errors++;
      $display("FAIL reset_grant got %h want 00", grant);
    end
    checks++;
    if (dut.r_state !== ARB_RUN) begin
      errors++;
      $display("FAIL reset_state got %0d want %0d",
               dut.r_state, ARB_RUN);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q_cnt[3] = 1; q_cmd[3] = mk(CMD_READ, 3);
    q_cnt[0] = 1; q_cmd[0] = mk(CMD_READ, 0);
    step(g);
    checks++;
    if (g !== 8'h01) begin
      errors++;
      $display("FAIL reset_first_grant got %h want 01", g);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] g;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      q_cnt[i] = 2;
      q_cmd[i] = mk(CMD_READ, i);
    end
    for (int k = 0; k < 9; k++) begin
      step(g);
      checks++;
      if (g !== 8'(1 << (k % 8))) begin
        errors++;
        $display("FAIL rr_grant k=%0d got %h want %h",
                 k, g, 8'(1 << (k % 8)));
      end
      checks++;
      if (wen !== 1'b1 ||
          issue_cmd !== mk(CMD_READ, k % 8)) begin
        errors++;
        $display("FAIL rr_issue k=%0d got wen=%0b cmd=%h want wen=1 cmd=%h",
                 k, wen, issue_cmd, mk(CMD_READ, k % 8));
      end
    end
  endtask

  task automatic test_trrd();
    logic [7:0] g;
    int gc [8];
    apply_reset();
    for (int i = 0; i < 8; i++) gc[i] = -1;
    q_cnt[0] = 1; q_cmd[0] = mk(CMD_ACTIVE, 0);
    q_cnt[1] = 1; q_cmd[1] = mk(CMD_ACTIVE, 1);
    q_cnt[2] = 1; q_cmd[2] = mk(CMD_READ, 2);
    for (int c = 0; c < 8; c++) begin
      step(g);
      for (int i = 0; i < 8; i++)
        if (g[i]) gc[i] = c;
      if (c == 4) begin
        checks++;
        if (wen !== 1'b1 ||
            issue_cmd !== mk(CMD_ACTIVE, 1)) begin
          errors++;
          $display("FAIL trrd_issue got wen=%0b cmd=%h want wen=1 cmd=%h",
                   wen, issue_cmd, mk(CMD_ACTIVE, 1));
        end
      end
    end
    checks++;
    if (gc[0] != 0) begin
      errors++;
      $display("FAIL trrd_b0 got cycle %0d want 0", gc[0]);
    end
    checks++;
    if (gc[2] != 1) begin
      errors++;
      $display("FAIL trrd_b2_read got cycle %0d want 1", gc[2]);
    end
    checks++;
    if (gc[1] != 4) begin
      errors++;
      $display("FAIL trrd_b1 got cycle %0d want 4", gc[1]);
    end
  endtask

  task automatic test_tfaw();
    logic [7:0] g;
    int gc [8];
    int exp_c [5];
    exp_c = '{0, 4, 8, 12, 20};
    apply_reset();
    for (int i = 0; i < 8; i++) gc[i] = -1;
    for (int i = 0; i < 5; i++) begin
      q_cnt[i] = 1;
      q_cmd[i] = mk(CMD_ACTIVE, i);
    end
    for (int c = 0; c < 24; c++) begin
      step(g);
      for (int i = 0; i < 8; i++)
        if (g[i]) gc[i] = c;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gc[i] != exp_c[i]) begin
        errors++;
        $display("FAIL tfaw_act%0d got cycle %0d want %0d",
                 i, gc[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_refresh();
    logic [7:0] g;
    bank_command_t em [$];
    int ack_at;
    int ref_at;
    int gwait;
    apply_reset();
    q_cnt[2] = 1; q_cmd[2] = mk(CMD_ACTIVE, 2);
    q_cnt[5] = 1; q_cmd[5] = mk(CMD_ACTIVE, 5);
    for (int c = 0; c < 6; c++) step(g);
    checks++;
    if (dut.r_open_bank !== 8'b0010_0100) begin
      errors++;
      $display("FAIL ref_open_before got %b want 00100100",
               dut.r_open_bank);
    end
    refresh_req = 1'b1;
    q_cnt[0] = 1; q_cmd[0] = mk(CMD_READ, 0);
    ack_at = -1;
    ref_at = -1;
    for (int c = 0; c < 20 && ack_at < 0; c++) begin
      step(g);
      checks++;
      if (g !== 8'h00) begin
        errors++;
        $display("FAIL ref_no_grant c=%0d got %h want 00", c, g);
      end
      if (wen) begin
        em.push_back(issue_cmd);
        if (issue_cmd.cmd == CMD_REFRESH) ref_at = c;
      end
      if (ack) ack_at = c;
    end
    refresh_req = 1'b0;
    checks++;
    if (ack_at < 0) begin
      errors++;
      $display("FAIL ref_ack_timeout got none want ack");
    end
    checks++;
    if (em.size() != 3) begin
      errors++;
      $display("FAIL ref_seq_len got %0d want 3", em.size());
    end else begin
      checks++;
      if (em[0].cmd !== CMD_PRECHARGE || em[0].bank_address !== 3'd2 ||
          em[1].cmd !== CMD_PRECHARGE || em[1].bank_address !== 3'd5 ||
          em[2].cmd !== CMD_REFRESH) begin
        errors++;
        $display("FAIL ref_seq got %h %h %h want PRE2 PRE5 REF",
                 em[0], em[1], em[2]);
      end
    end
    // ack and REFRESH write both register on the REFRESH grant edge
    checks++;
    if (ack_at != ref_at) begin
      errors++;
      $display("FAIL ref_ack_timing got ack=%0d want %0d",
               ack_at, ref_at);
    end
    checks++;
    if (dut.r_open_bank !== 8'h00) begin
      errors++;
      $display("FAIL ref_open_after got %b want 0", dut.r_open_bank);
    end
    step(g);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL ref_ack_pulse got %0b want 0", ack);
    end
    gwait = 0;
    while (g === 8'h00 && gwait < 4) begin
      step(g);
      gwait++;
    end
    checks++;
    if (g !== 8'h01) begin
      errors++;
      $display("FAIL ref_resume got %h want 01", g);
    end
  endtask

  task automatic test_full();
    logic [7:0] g;
    int ei;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      q_cnt[i] = 3;
      q_cmd[i] = mk(CMD_READ, i);
    end
    for (int c = 0; c < 10; c++) begin
      full = (c >= 3 && c <= 6);
      step(g);
      if (c >= 3 && c <= 6) begin
        checks++;
        if (g !== 8'h00 || wen !== 1'b0) begin
          errors++;
          $display("FAIL full_hold c=%0d got g=%h wen=%0b want 00/0",
                   c, g, wen);
        end
      end else begin
        ei = (c < 3) ? c : c - 4;
        checks++;
        if (g !== 8'(1 << ei) || wen !== 1'b1) begin
          errors++;
          $display("FAIL full_grant c=%0d got g=%h wen=%0b want %h/1",
                   c, g, wen, 8'(1 << ei));
        end
      end
    end
    full = 1'b0;
  endtask

  task automatic test_reset_mid_refresh();
    logic [7:0] g;
    apply_reset();
    q_cnt[3] = 1; q_cmd[3] = mk(CMD_ACTIVE, 3);
    step(g);
    refresh_req = 1'b1;
    step(g);
    full = 1'b1;
    step(g);
    step(g);
    checks++;
    if (dut.r_state !== ARB_REF_PRE) begin
      errors++;
      $display("FAIL mid_ref_state got %0d want %0d",
               dut.r_state, ARB_REF_PRE);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (wen !== 1'b0 || ack !== 1'b0 || grant !== 8'h00 ||
        issue_cmd !== bank_command_t'('0)) begin
      errors++;
      $display("FAIL mid_ref_outputs got wen=%0b ack=%0b g=%h cmd=%h want 0",
               wen, ack, grant, issue_cmd);
    end
    checks++;
    if (dut.r_state !== ARB_RUN || dut.r_open_bank !== 8'h00) begin
      errors++;
      $display("FAIL mid_ref_state_rst got st=%0d open=%b want RUN/0",
               dut.r_state, dut.r_open_bank);
    end
    #2;
    rst_n = 1'b1;
    refresh_req = 1'b0;
    full = 1'b0;
    clear_q();
    q_cnt[0] = 1; q_cmd[0] = mk(CMD_READ, 0);
    q_cnt[5] = 1; q_cmd[5] = mk(CMD_READ, 5);
    step(g);
    checks++;
    if (g !== 8'h01) begin
      errors++;
      $display("FAIL mid_ref_next_grant got %h want 01", g);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    refresh_req = 1'b0;
    full = 1'b0;
    req_valid = '0;
    req_cmd = '0;
    clear_q();
    test_reset();
    test_round_robin();
    test_trrd();
    test_tfaw();
    test_refresh();
    test_full();
    test_reset_mid_refresh();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
